hp0_read_master: RTL and testbench
==================================

Name: hp0_read_master

Overview:
- AXI3 read master on the PS HP0 slave port. It is the read-side counterpart of the existing HP0 write DMA.
- Fetches a block of 64-bit words from DDR, for example a DAC waveform table or lock-parameter table written by the PS. Uses INCR bursts of up to 16 beats.
- Presents each word on a valid/ready stream with its beat index, so a downstream BRAM writer can store it.
- Runs in the fclk0 domain. Drives the HP0 AR/R inputs that are currently tied off in the top level.

Parameters:
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width. Fixed at 64; a different value is unsupported.
- LEN_WIDTH, 16, width of the beat-count request and of the index output.
- MAX_BURST, 16, beats per burst. AXI3 limit; must be a power of 2 and at most 16.

Ports:
- aclk  in  1  AXI clock (fclk0)
- rst_i  in  1  asynchronous active-high reset
- m_axi_araddr  out  ADDR_WIDTH  burst start address
- m_axi_arvalid  out  1  AR valid
- m_axi_arready  in  1  AR ready
- m_axi_arlen  out  4  beats-1
- m_axi_arsize  out  3  constant 3'b011 (8 bytes)
- m_axi_arburst  out  2  constant 2'b01 (INCR)
- m_axi_rdata  in  DATA_WIDTH  read data
- m_axi_rresp  in  2  read response
- m_axi_rlast  in  1  last beat of burst
- m_axi_rvalid  in  1  R valid
- m_axi_rready  out  1  R ready
- enable_i  in  1  level request; start and 4-phase release
- base_addr_i  in  ADDR_WIDTH  byte address; must be MAX_BURST*8 aligned
- beats_i  in  LEN_WIDTH  number of 64-bit words to read
- data_o  out  DATA_WIDTH  stream data
- valid_o  out  1  stream valid
- ready_i  in  1  stream ready
- index_o  out  LEN_WIDTH  beat index of data_o, starting at 0
- engaged_o  out  1  transfer in progress
- finished_o  out  1  transfer complete; held until enable_i falls
- error_o  out  1  sticky error for the current transfer

Behaviour:
- All reset values are 0: arvalid, araddr, arlen, data_o, valid_o, index_o, engaged_o, finished_o, error_o, and the state (IDLE). arsize and arburst are constants.
- States are IDLE, ADDR, DATA, DONE.
- IDLE:
  - If enable_i=1, latch base_addr_i and beats_i, clear error_o, and set engaged_o=1.
  - If base is misaligned (low log2(MAX_BURST*8) bits nonzero), set error_o=1 and go to DONE.
  - Else if beats_i=0, go to DONE.
  - Else go to ADDR.
- ADDR:
  - Drive araddr = current address and arlen = min(remaining, MAX_BURST)-1. Hold arvalid=1 with address and length stable until arready.
  - On arvalid&&arready, go to DATA.
  - Aligned bursts never cross a 4 KB boundary.
- DATA:
  - m_axi_rready = ready_i (combinational). valid_o = m_axi_rvalid and data_o = m_axi_rdata, both combinational pass-through.
  - index_o is a registered running count that increments on each accepted beat (rvalid&&rready).
  - On rresp != 2'b00, set error_o; the data is still forwarded.
  - If rlast disagrees with the expected last beat of the burst, set error_o. The burst ends on the expected count, not on rlast.
  - At burst end: remaining -= burst length and address += burst length*8. If remaining > 0 go to ADDR, else go to DONE.
  - Only one burst is outstanding at a time.
- DONE:
  - engaged_o=0, finished_o=1.
  - When enable_i=0, clear finished_o and go to IDLE.
  - enable_i held high in DONE does not restart a transfer.
- Changes to enable_i, base_addr_i or beats_i after the start are ignored until DONE.
- Latency: arvalid rises 1 cycle after enable_i is sampled in IDLE. Each new burst's arvalid rises 1 cycle after the previous burst's last accepted beat.
- Reset mid-transfer aborts immediately and all outputs go to reset values. The HP0 port must be reset together with this block; software must not assert reset while engaged_o=1.

Decomposition:
- Package pdh_axi_pkg holds:
  - the state enum rd_state_t;
  - AXI_SIZE_8B=3'b011, AXI_BURST_INCR=2'b01;
  - AXI_RESP_OKAY, AXI_RESP_SLVERR, AXI_RESP_DECERR;
  - BEAT_BYTES=8.
- The write DMA shares this package.
- No sub-module: single FSM, remaining/address counters and a beat counter.

Test Plan:
- base=0x1000_0000, beats=32, ready_i=1, arready and rvalid always high:
  - two ARs, (0x1000_0000, arlen 15) then (0x1000_0080, arlen 15);
  - 32 outputs with index 0..31 in order;
  - finished_o=1, error_o=0; finished_o clears 1 cycle after enable_i falls.
- beats=20: ARs at 0x...0000 with arlen 15, then 0x...0080 with arlen 3. Exactly 20 stream beats.
- beats=0: no arvalid; finished_o=1 within 2 cycles of enable_i.
- base=0x1000_0008: error_o=1, finished_o=1, no arvalid.
- Backpressure, beats=16 with ready_i toggling 1/0 per cycle and random rvalid gaps:
  - m_axi_rready tracks ready_i;
  - output data equals the memory-model pattern (addr>>3) for every index;
  - no beat dropped or duplicated.
- rresp=SLVERR on beat 5 of 16: error_o=1 from beat 5 onward; all 16 beats still delivered; finished_o=1.
- Async rst_i pulse during DATA of burst 2: all outputs go to 0 within the same cycle. A new transfer after reset runs correctly.

Source files
------------

// File: rtl/pdh_axi_pkg.sv
// Shared AXI3 definitions for the HP0 read and write DMA engines.
package pdh_axi_pkg;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA,
        RD_DONE
    } rd_state_t;

    localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam int BEAT_BYTES = 8;

endpackage

// File: rtl/hp0_read_master.sv
// AXI3 INCR read master on HP0: fetches a block of 64-bit words and streams
// them out with their beat index. One burst outstanding at a time.
module hp0_read_master
    import pdh_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                  aclk,
    input  logic                  rst_i,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [3:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic                  enable_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  beats_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [LEN_WIDTH-1:0]  index_o,
    output logic                  engaged_o,
    output logic                  finished_o,
    output logic                  error_o
);

    localparam int ALIGN_BITS = $clog2(MAX_BURST * BEAT_BYTES);
    localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
    localparam int BL_W       = $clog2(MAX_BURST) + 1;

    rd_state_t             state, state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  rem_q;
    logic [LEN_WIDTH-1:0]  idx_q;
    logic [LEN_WIDTH-1:0]  rem_after;
    logic [BL_W-1:0]       blen_q;
    logic [BL_W-1:0]       beat_q;
    logic [BL_W-1:0]       blen_nx;
    logic                  err_q;
    logic                  misaligned;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  last_exp;
    logic                  burst_end;

    assign misaligned = |base_addr_i[ALIGN_BITS-1:0];
    assign blen_nx    = (rem_q >= LEN_WIDTH'(MAX_BURST)) ? BL_W'(MAX_BURST) : BL_W'(rem_q);
    assign ar_hs      = (state == RD_ADDR) && m_axi_arready;
    assign r_hs       = (state == RD_DATA) && m_axi_rvalid && ready_i;
    assign last_exp   = (beat_q == blen_q - 1'b1);
    assign burst_end  = r_hs && last_exp;
    assign rem_after  = rem_q - LEN_WIDTH'(blen_q);

    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) state <= RD_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RD_IDLE: begin
                if (enable_i) begin
                    if (misaligned || beats_i == '0) state_nx = RD_DONE;
                    else                             state_nx = RD_ADDR;
                end
            end
            RD_ADDR: if (ar_hs) state_nx = RD_DATA;
            RD_DATA: begin
                if (burst_end) state_nx = (rem_after != '0) ? RD_ADDR : RD_DONE;
            end
            RD_DONE: if (!enable_i) state_nx = RD_IDLE;
            default: state_nx = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            rem_q  <= '0;
            idx_q  <= '0;
            blen_q <= '0;
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == RD_IDLE && enable_i) begin
                addr_q <= base_addr_i;
                rem_q  <= beats_i;
                idx_q  <= '0;
                beat_q <= '0;
                err_q  <= misaligned;
            end
            if (ar_hs) begin
                blen_q <= blen_nx;
                beat_q <= '0;
            end
            if (r_hs) begin
                idx_q  <= idx_q + 1'b1;
                beat_q <= beat_q + 1'b1;
                // burst length is counted locally; rlast is only cross-checked
                if (m_axi_rresp != AXI_RESP_OKAY || m_axi_rlast != last_exp)
                    err_q <= 1'b1;
            end
            if (burst_end) begin
                rem_q  <= rem_after;
                addr_q <= addr_q + (ADDR_WIDTH'(blen_q) << BEAT_SHIFT);
            end
        end
    end

    assign m_axi_arvalid = (state == RD_ADDR);
    assign m_axi_araddr  = (state == RD_ADDR) ? addr_q : '0;
    assign m_axi_arlen   = (state == RD_ADDR) ? 4'(blen_nx - 1'b1) : 4'd0;
    assign m_axi_arsize  = AXI_SIZE_8B;
    assign m_axi_arburst = AXI_BURST_INCR;

    assign m_axi_rready  = (state == RD_DATA) && ready_i;
    assign valid_o       = (state == RD_DATA) && m_axi_rvalid;
    assign data_o        = (state == RD_DATA) ? m_axi_rdata : '0;
    assign index_o       = idx_q;

    assign engaged_o     = (state == RD_ADDR) || (state == RD_DATA);
    assign finished_o    = (state == RD_DONE);
    assign error_o       = err_q;

endmodule

// File: tb/tb_hp0_read_master.sv
// Directed bench for hp0_read_master with a small AXI3 read slave model.
module tb_hp0_read_master;
    import pdh_axi_pkg::*;

    logic        aclk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b1;
    logic [3:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic [63:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = 2'b00;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic        enable_i = 1'b0;
    logic [31:0] base_addr_i = '0;
    logic [15:0] beats_i = '0;
    logic [63:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [15:0] index_o;
    logic        engaged_o;
    logic        finished_o;
    logic        error_o;

    hp0_read_master dut (
        .aclk(aclk), .rst_i(rst_i),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready), .enable_i(enable_i),
        .base_addr_i(base_addr_i), .beats_i(beats_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .index_o(index_o), .engaged_o(engaged_o),
        .finished_o(finished_o), .error_o(error_o)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // slave model / stream monitor state
    int          ready_mode = 0;
    int          gap_mode   = 0;
    int          err_beat   = -1;
    int          n_ar, n_beat, gb, viol;
    logic [31:0] ar_addr [8];
    logic [3:0]  ar_len  [8];
    logic [63:0] b_data  [64];
    logic [15:0] b_idx   [64];
    logic        b_err   [64];
    logic        have_burst = 1'b0;
    logic        r_hold = 1'b0;
    logic        ar_pend = 1'b0;
    logic [31:0] ar_pend_addr;
    logic [3:0]  ar_pend_len;
    logic [31:0] s_addr = '0;
    int          s_left = 0;

    // Observe at negedge (all drivers settled), drive at posedge+1.
    initial begin
        n_ar = 0; n_beat = 0; gb = 0; viol = 0;
        forever begin
            @(negedge aclk);
            if (rst_i) begin
                have_burst = 1'b0;
                ar_pend    = 1'b0;
                r_hold     = 1'b0;
            end else begin
                if (ar_pend && !(m_axi_arvalid && m_axi_araddr == ar_pend_addr &&
                                 m_axi_arlen == ar_pend_len))
                    viol++;
                ar_pend      = m_axi_arvalid && !m_axi_arready;
                ar_pend_addr = m_axi_araddr;
                ar_pend_len  = m_axi_arlen;
                if (have_burst && (m_axi_rready !== ready_i || valid_o !== m_axi_rvalid ||
                                   data_o !== m_axi_rdata))
                    viol++;
                r_hold = m_axi_rvalid && !m_axi_rready;
                if (m_axi_rvalid && m_axi_rready) begin
                    if (n_beat < 64) begin
                        b_data[n_beat] = data_o;
                        b_idx[n_beat]  = index_o;
                        b_err[n_beat]  = error_o;
                    end
                    n_beat++;
                    gb++;
                    s_addr = s_addr + 32'd8;
                    s_left--;
                    if (s_left <= 0) have_burst = 1'b0;
                end
                if (m_axi_arvalid && m_axi_arready) begin
                    if (n_ar < 8) begin
                        ar_addr[n_ar] = m_axi_araddr;
                        ar_len[n_ar]  = m_axi_arlen;
                    end
                    n_ar++;
                    have_burst = 1'b1;
                    s_addr     = m_axi_araddr;
                    s_left     = int'(m_axi_arlen) + 1;
                end
            end
            @(posedge aclk);
            #1;
            m_axi_arready = gap_mode != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
            ready_i       = ready_mode != 0 ? ~ready_i : 1'b1;
            m_axi_rvalid  = have_burst && (r_hold || gap_mode == 0 || $urandom_range(0, 2) != 0);
            m_axi_rdata   = 64'(s_addr >> 3);
            m_axi_rlast   = (s_left == 1);
            m_axi_rresp   = (gb == err_beat) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        end
    end

    typedef struct {
        logic [31:0] base;
        int          beats;
        int          rmode;
        int          gmode;
        int          eb;
        int          nar;
        logic [31:0] a1;
        logic [3:0]  l0;
        logic [3:0]  l1;
        int          nb;
        logic        err;
    } vec_t;

    vec_t vt [6];

    task automatic run_xfer(input vec_t v, input string tag);
        int cyc;
        int beat_bad;
        int err_bad;
        logic [63:0] exp_d;
        ready_mode = v.rmode;
        gap_mode   = v.gmode;
        err_beat   = v.eb;
        n_ar = 0; n_beat = 0; gb = 0; viol = 0;
        @(posedge aclk); #2;
        base_addr_i = v.base;
        beats_i     = 16'(v.beats);
        enable_i    = 1'b1;
        cyc = 0;
        while (!finished_o && cyc < 3000) begin
            @(posedge aclk); #2;
            cyc++;
        end
        chk({tag, " timeout"}, 64'(cyc >= 3000), 64'd0);
        chk({tag, " n_ar"}, 64'(n_ar), 64'(v.nar));
        if (v.nar > 0) begin
            chk({tag, " ar0_addr"}, 64'(ar_addr[0]), 64'(v.base));
            chk({tag, " ar0_len"}, 64'(ar_len[0]), 64'(v.l0));
        end
        if (v.nar > 1) begin
            chk({tag, " ar1_addr"}, 64'(ar_addr[1]), 64'(v.a1));
            chk({tag, " ar1_len"}, 64'(ar_len[1]), 64'(v.l1));
        end
        if (v.nb == 0) chk({tag, " done_latency_le2"}, 64'(cyc <= 2), 64'd1);
        chk({tag, " n_beat"}, 64'(n_beat), 64'(v.nb));
        beat_bad = 0;
        err_bad  = 0;
        for (int i = 0; i < v.nb && i < n_beat && i < 64; i++) begin
            exp_d = 64'(v.base >> 3) + 64'(i);
            if (b_data[i] !== exp_d || b_idx[i] !== 16'(i)) beat_bad++;
            // error_o is registered, so it is seen on the beat after the bad one
            if (b_err[i] !== (v.eb >= 0 && i > v.eb)) err_bad++;
        end
        chk({tag, " beat_data_index_bad"}, 64'(beat_bad), 64'd0);
        chk({tag, " error_timeline_bad"}, 64'(err_bad), 64'd0);
        chk({tag, " protocol_viol"}, 64'(viol), 64'd0);
        chk({tag, " error_o"}, 64'(error_o), 64'(v.err));
        chk({tag, " engaged_at_done"}, 64'(engaged_o), 64'd0);
        chk({tag, " index_final"}, 64'(index_o), 64'(v.nb));
        enable_i = 1'b0;
        @(posedge aclk); #2;
        chk({tag, " finished_clears"}, 64'(finished_o), 64'd0);
        ready_mode = 0;
        gap_mode   = 0;
        err_beat   = -1;
    endtask

    initial begin
        int cyc;
        vt[0] = '{32'h1000_0000, 32, 0, 0, -1, 2, 32'h1000_0080, 4'd15, 4'd15, 32, 1'b0};
        vt[1] = '{32'h1000_0000, 20, 0, 0, -1, 2, 32'h1000_0080, 4'd15, 4'd3,  20, 1'b0};
        vt[2] = '{32'h1000_0000,  0, 0, 0, -1, 0, 32'h0,         4'd0,  4'd0,   0, 1'b0};
        vt[3] = '{32'h1000_0008, 16, 0, 0, -1, 0, 32'h0,         4'd0,  4'd0,   0, 1'b1};
        vt[4] = '{32'h1000_0100, 16, 1, 1, -1, 1, 32'h0,         4'd15, 4'd0,  16, 1'b0};
        vt[5] = '{32'h1000_0000, 16, 0, 0,  5, 1, 32'h0,         4'd15, 4'd0,  16, 1'b1};

        #12;
        chk("reset_outputs",
            {m_axi_arvalid, m_axi_rready, valid_o, engaged_o, finished_o, error_o,
             m_axi_arlen, index_o, m_axi_araddr[9:0]}, 64'd0);
        chk("reset_data_o", data_o, 64'd0);
        chk("arsize_const", 64'(m_axi_arsize), 64'(3'b011));
        chk("arburst_const", 64'(m_axi_arburst), 64'(2'b01));
        @(posedge aclk); #3;
        rst_i = 1'b0;

        for (int k = 0; k < 6; k++) run_xfer(vt[k], $sformatf("vec%0d", k));

        // async reset in the middle of the second burst
        n_ar = 0; n_beat = 0; gb = 0; viol = 0;
        @(posedge aclk); #2;
        base_addr_i = 32'h2000_0000;
        beats_i     = 16'd32;
        enable_i    = 1'b1;
        cyc = 0;
        while (gb < 20 && cyc < 200) begin
            @(posedge aclk); #2;
            cyc++;
        end
        chk("rst_reach_burst2", 64'(gb >= 20 && n_ar == 2), 64'd1);
        @(posedge aclk); #3;
        rst_i = 1'b1;
        #1;
        chk("rst_mid_outputs",
            {m_axi_arvalid, m_axi_rready, valid_o, engaged_o, finished_o, error_o,
             m_axi_arlen, index_o, m_axi_araddr[9:0]}, 64'd0);
        chk("rst_mid_data_o", data_o, 64'd0);
        chk("rst_mid_araddr", 64'(m_axi_araddr), 64'd0);
        enable_i = 1'b0;
        repeat (2) @(posedge aclk);
        #3;
        rst_i = 1'b0;
        run_xfer(vt[0], "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
